// File: rtl/layer3_buf_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// layer3_buf_ctrl_pkg -- shared local-buffer definitions.
//   LB_DEPTH / LB_AW / LB_DW : default SRAM depth, address width, word width
//   lb_state_t               : controller state encoding (IDLE, RUN, FLUSH)
// ---------------------------------------------------------------------------
package layer3_buf_ctrl_pkg;

  localparam int LB_DEPTH = 208;
  localparam int LB_AW    = 8;
  localparam int LB_DW    = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } lb_state_t;

endpackage

// File: rtl/layer3_buf_ctrl_skid2.sv
// ---------------------------------------------------------------------------
// lb_skid2 -- two-entry output buffer sitting behind the SRAM read port.
//   clk, rst          : clock, synchronous active-high reset
//   clear             : synchronous discard of all entries
//   push, push_data   : capture one word (caller guarantees a free slot)
//   pop               : release the oldest entry
//   occ               : number of valid entries (0..2)
//   head_data         : oldest entry (0 after reset/clear)
// Push and pop in the same cycle are allowed.
// ---------------------------------------------------------------------------
module lb_skid2
  import layer3_buf_ctrl_pkg::*;
#(
  parameter int DW = LB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [1:0]    occ,
  output logic [DW-1:0] head_data
);

  logic [DW-1:0] mem0;
  logic [DW-1:0] mem1;
  logic          head;
  logic          tail;

  // Free slot is the one after the head when one entry is held, else the head.
  assign tail      = head ^ occ[0];
  assign head_data = head ? mem1 : mem0;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      mem0 <= '0;
      mem1 <= '0;
      head <= 1'b0;
      occ  <= 2'd0;
    end else begin
      if (push) begin
        if (tail) mem1 <= push_data;
        else      mem0 <= push_data;
      end
      if (pop) head <= ~head;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/layer3_buf_ctrl.sv
// ---------------------------------------------------------------------------
// layer3_buf_ctrl -- circular FIFO controller for an external dual-port SRAM
// (port A write-only, port B read-only) with a 2-entry output buffer.
//   CK, rst                 : clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_data : producer side
//   rd_valid/rd_ready/rd_data : consumer side
//   flush                   : discard everything buffered
//   count, full, empty      : words held in SRAM (output buffer excluded)
//   sram_*                  : SRAM port controls; sram_DOB is valid the cycle
//                             after a read address is presented
//   dbg_state               : current controller state (lb_state_t encoding)
// Handshake: a word moves on a cycle where valid && ready are both high at
// the rising edge; valid never depends on ready of the same interface.
// ---------------------------------------------------------------------------
module layer3_buf_ctrl
  import layer3_buf_ctrl_pkg::*;
#(
  parameter int DEPTH = LB_DEPTH,
  parameter int AW    = LB_AW,
  parameter int DW    = LB_DW
) (
  input  logic          CK,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  input  logic          flush,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] sram_A,
  output logic [AW-1:0] sram_B,
  output logic          sram_WEAN,
  output logic          sram_WEBN,
  output logic          sram_OEA,
  output logic          sram_OEB,
  output logic [DW-1:0] sram_DIA,
  output logic [DW-1:0] sram_DIB,
  input  logic [DW-1:0] sram_DOB,
  output logic [1:0]    dbg_state
);

  lb_state_t     state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic          inflight;
  logic [1:0]    obuf_occ;
  logic [2:0]    credit;
  logic          do_wr, do_issue, do_pop, do_clear;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count_q == (AW + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign wr_ready = !full && (state == ST_RUN);
  assign rd_valid = (obuf_occ != 2'd0) && (state == ST_RUN);

  assign do_wr  = wr_valid && wr_ready;
  assign do_pop = rd_valid && rd_ready;

  // Buffer slots already spoken for: held entries plus the read in flight,
  // minus the slot this cycle's pop releases. Counting the pop keeps the
  // stream at one word per cycle once the pipeline is primed.
  assign credit   = {1'b0, obuf_occ} + {2'b00, inflight} - {2'b00, do_pop};
  // No issue on the flush cycle: the word would be thrown away anyway, and
  // keeping inflight clear lets FLUSH finish in a single cycle.
  assign do_issue = (state == ST_RUN) && !flush && !empty && (credit < 3'd2);
  assign do_clear = (state == ST_FLUSH) && !inflight;

  assign sram_A    = wr_ptr;
  assign sram_WEAN = !do_wr;
  assign sram_DIA  = wr_data;
  assign sram_OEA  = 1'b0;
  assign sram_B    = rd_ptr;
  assign sram_OEB  = do_issue;
  assign sram_WEBN = 1'b1;
  assign sram_DIB  = '0;
  assign dbg_state = state;

  always_ff @(posedge CK) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_RUN;
      ST_RUN:   if (flush) state_nxt = ST_FLUSH;
      ST_FLUSH: if (!inflight) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (rst || do_clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr)    wr_ptr <= ptr_inc(wr_ptr);
      if (do_issue) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_wr, do_issue})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Reset drops the pending read so its sram_DOB word is never captured.
  always_ff @(posedge CK) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= do_issue;
  end

  lb_skid2 #(.DW(DW)) u_obuf (
    .clk       (CK),
    .rst       (rst),
    .clear     (do_clear),
    .push      (inflight),
    .push_data (sram_DOB),
    .pop       (do_pop),
    .occ       (obuf_occ),
    .head_data (rd_data)
  );

endmodule

// File: tb/tb_layer3_buf_ctrl.sv
module tb_layer3_buf_ctrl;

  localparam int DEPTH = 208;
  localparam int AW    = 8;
  localparam int DW    = 128;
  localparam int NV    = 16;

  logic          CK = 1'b0;
  logic          rst, wr_valid, rd_ready, flush;
  logic [DW-1:0] wr_data;
  logic          wr_ready, rd_valid, full, empty;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic [AW-1:0] sram_A, sram_B;
  logic          sram_WEAN, sram_WEBN, sram_OEA, sram_OEB;
  logic [DW-1:0] sram_DIA, sram_DIB, sram_DOB;
  logic [1:0]    dbg_state;

  always #5 CK = ~CK;

  layer3_buf_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CK(CK), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .flush(flush), .count(count), .full(full), .empty(empty),
    .sram_A(sram_A), .sram_B(sram_B),
    .sram_WEAN(sram_WEAN), .sram_WEBN(sram_WEBN),
    .sram_OEA(sram_OEA), .sram_OEB(sram_OEB),
    .sram_DIA(sram_DIA), .sram_DIB(sram_DIB), .sram_DOB(sram_DOB),
    .dbg_state(dbg_state)
  );

  // SRAM model: write on A, registered read on B; garbage when not reading.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge CK) begin
    if (!sram_WEAN) mem[sram_A] <= sram_DIA;
    if (sram_OEB) sram_DOB <= mem[sram_B];
    else          sram_DOB <= {$urandom, $urandom, $urandom, $urandom};
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired or event missing", name);
  endtask

  logic [DW-1:0] exp_q[$];
  int  n_wr, n_iss, sram_words, cyc;
  int  ph_wr, wr_first, wr_last, pop_n, pop_first, pop_last;
  bit  mon_en;

  task automatic model_clear();
    exp_q.delete();
    n_wr  = 0;
    n_iss = 0;
  endtask

  task automatic phase_clear();
    ph_wr = 0; wr_first = 0; wr_last = 0;
    pop_n = 0; pop_first = 0; pop_last = 0;
  endtask

  // Reference: SRAM holds writes minus issues; addresses follow the running
  // write/issue totals modulo DEPTH; data leaves in arrival order.
  always @(negedge CK) begin
    cyc = cyc + 1;
    if (mon_en) begin
      sram_words = n_wr - n_iss;
      check("count", 128'(count), 128'(sram_words));
      check("full", 128'(full), 128'(sram_words == DEPTH));
      check("empty", 128'(empty), 128'(sram_words == 0));
      check("wr_ready", 128'(wr_ready), 128'(sram_words < DEPTH));
      check("held_words", 128'((exp_q.size() >= sram_words) && (exp_q.size() <= sram_words + 2)), 128'(1));
      check("wean", 128'(sram_WEAN), 128'(!(wr_valid && wr_ready)));
      if (wr_valid && wr_ready) begin
        check("wr_addr", 128'(sram_A), 128'(n_wr % DEPTH));
        exp_q.push_back(wr_data);
        if (ph_wr == 0) wr_first = cyc;
        wr_last = cyc;
        ph_wr++;
        n_wr++;
      end
      if (sram_OEB) begin
        check("rd_addr", 128'(sram_B), 128'(n_iss % DEPTH));
        check("issue_nonempty", 128'(sram_words > 0), 128'(1));
        n_iss++;
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) fail_now("pop_underflow");
        else check("rd_data", rd_data, exp_q.pop_front());
        if (pop_n == 0) pop_first = cyc;
        pop_last = cyc;
        pop_n++;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst, wv, rr, fl;
    logic [15:0] wd;
    logic       e_wrdy, e_rvld;
    logic [15:0] e_rd;
    logic [8:0] e_cnt;
    logic       e_wean;
    logic [7:0] e_a;
    logic       e_oeb;
    logic [1:0] e_st;
  } vec_t;

  vec_t tbl [NV];

  initial begin
    rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0; wr_data = '0;
    mon_en = 1'b0; cyc = 0;
    model_clear();
    phase_clear();

    //            rst   wv    rr    fl    wd        wrdy  rvld  rd        cnt   wean  a     oeb   st
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0AA0, 1'b0, 1'b0, 16'h0000, 9'd0, 1'b1, 8'd0, 1'b0, 2'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1111, 1'b1, 1'b0, 16'h0000, 9'd0, 1'b0, 8'd0, 1'b0, 2'd1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 9'd1, 1'b1, 8'd0, 1'b1, 2'd1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 9'd0, 1'b1, 8'd0, 1'b0, 2'd1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1111, 9'd0, 1'b1, 8'd0, 1'b0, 2'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h0000, 9'd0, 1'b1, 8'd0, 1'b0, 2'd1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b0, 16'h0000, 9'd0, 1'b1, 8'd0, 1'b0, 2'd2};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h3333, 1'b1, 1'b0, 16'h0000, 9'd0, 1'b0, 8'd0, 1'b0, 2'd1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h4444, 1'b1, 1'b0, 16'h0000, 9'd1, 1'b0, 8'd1, 1'b1, 2'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 9'd1, 1'b1, 8'd0, 1'b1, 2'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h3333, 9'd0, 1'b1, 8'd0, 1'b0, 2'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h3333, 9'd0, 1'b1, 8'd0, 1'b0, 2'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h4444, 9'd0, 1'b1, 8'd0, 1'b0, 2'd1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 9'd0, 1'b1, 8'd0, 1'b0, 2'd1};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h5555, 1'b1, 1'b0, 16'h0000, 9'd0, 1'b0, 8'd2, 1'b0, 2'd1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 9'd0, 1'b1, 8'd0, 1'b0, 2'd0};

    repeat (2) @(posedge CK);

    // ---- table: latency, ordering, flush, reset override ----
    for (int i = 0; i < NV; i++) begin
      @(posedge CK); #1;
      rst = tbl[i].rst; wr_valid = tbl[i].wv; rd_ready = tbl[i].rr;
      flush = tbl[i].fl; wr_data = 128'(tbl[i].wd);
      @(negedge CK);
      check($sformatf("r%0d_state", i), 128'(dbg_state), 128'(tbl[i].e_st));
      check($sformatf("r%0d_wr_ready", i), 128'(wr_ready), 128'(tbl[i].e_wrdy));
      check($sformatf("r%0d_rd_valid", i), 128'(rd_valid), 128'(tbl[i].e_rvld));
      check($sformatf("r%0d_count", i), 128'(count), 128'(tbl[i].e_cnt));
      check($sformatf("r%0d_empty", i), 128'(empty), 128'(tbl[i].e_cnt == 9'd0));
      check($sformatf("r%0d_full", i), 128'(full), 128'(tbl[i].e_cnt == 9'(DEPTH)));
      check($sformatf("r%0d_wean", i), 128'(sram_WEAN), 128'(tbl[i].e_wean));
      check($sformatf("r%0d_oeb", i), 128'(sram_OEB), 128'(tbl[i].e_oeb));
      check($sformatf("r%0d_fixed", i), 128'({sram_WEBN, sram_OEA}), 128'(2'b10));
      check($sformatf("r%0d_dib", i), sram_DIB, 128'(0));
      if (tbl[i].e_rvld) check($sformatf("r%0d_rd_data", i), rd_data, 128'(tbl[i].e_rd));
      if (!tbl[i].e_wean) check($sformatf("r%0d_addr_a", i), 128'(sram_A), 128'(tbl[i].e_a));
    end

    // ---- fill with rd_ready low until the block stalls ----
    @(posedge CK); #1;
    model_clear(); phase_clear();
    mon_en = 1'b1; rd_ready = 1'b0;
    repeat (230) begin
      wr_valid = 1'b1; wr_data = 128'(n_wr);
      @(posedge CK); #1;
    end
    wr_valid = 1'b0;
    repeat (3) @(posedge CK);
    @(negedge CK);
    check("fill_accepted", 128'(n_wr), 128'(DEPTH + 2));
    check("fill_full", 128'(full), 128'(1));
    check("fill_count", 128'(count), 128'(DEPTH));
    check("fill_wr_ready", 128'(wr_ready), 128'(0));
    check("fill_head", rd_data, 128'(0));
    check("fill_rd_valid", 128'(rd_valid), 128'(1));

    // ---- drain everything back, no gap across the wrap ----
    @(posedge CK); #1;
    phase_clear(); rd_ready = 1'b1;
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge CK);
    #1;
    if (exp_q.size() != 0) fail_now("drain_timeout");
    check("drain_pops", 128'(pop_n), 128'(DEPTH + 2));
    check("drain_no_gap", 128'(pop_last - pop_first + 1), 128'(pop_n));

    // ---- stream 1000 words with rd_ready held high ----
    repeat (2) @(posedge CK); #1;
    phase_clear();
    for (int k = 0; k < 1100; k++) begin
      if (ph_wr >= 1000) break;
      wr_valid = 1'b1; wr_data = 128'(5000 + ph_wr);
      @(posedge CK); #1;
    end
    wr_valid = 1'b0;
    if (ph_wr < 1000) fail_now("stream_write_timeout");
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge CK);
    #1;
    if (exp_q.size() != 0) fail_now("stream_drain_timeout");
    check("stream_writes_back_to_back", 128'(wr_last - wr_first + 1), 128'(1000));
    check("stream_pops", 128'(pop_n), 128'(1000));
    check("stream_one_per_cycle", 128'(pop_last - pop_first + 1), 128'(1000));
    check("stream_fill_latency", 128'(pop_first - wr_first), 128'(3));

    // ---- random producer / consumer ----
    for (int k = 0; k < 800; k++) begin
      wr_valid = ($urandom_range(0, 9) < 7);
      rd_ready = $urandom_range(0, 1) == 1;
      wr_data  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge CK); #1;
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge CK);
    #1;
    if (exp_q.size() != 0) fail_now("random_drain_timeout");
    @(negedge CK);
    check("random_count_end", 128'(count), 128'(0));

    // ---- flush with a read in flight ----
    @(posedge CK); #1;
    mon_en = 1'b0; rd_ready = 1'b0;
    wr_valid = 1'b1; wr_data = 128'(16'hBEEF);
    @(posedge CK); #1;
    wr_valid = 1'b0;
    @(negedge CK);
    check("flush_issue_seen", 128'(sram_OEB), 128'(1));
    @(posedge CK); #1;
    flush = 1'b1;
    @(negedge CK);
    check("flush_cycle_state", 128'(dbg_state), 128'(1));
    @(posedge CK); #1;
    flush = 1'b0;
    @(negedge CK);
    check("flush_state", 128'(dbg_state), 128'(2));
    check("flush_wr_ready", 128'(wr_ready), 128'(0));
    check("flush_rd_valid", 128'(rd_valid), 128'(0));
    check("flush_no_issue", 128'(sram_OEB), 128'(0));
    @(posedge CK); #1;
    model_clear();
    mon_en = 1'b1; rd_ready = 1'b1;
    wr_valid = 1'b1; wr_data = 128'(16'hCAFE);
    @(negedge CK);
    check("post_flush_state", 128'(dbg_state), 128'(1));
    check("post_flush_rd_valid", 128'(rd_valid), 128'(0));
    check("post_flush_wean", 128'(sram_WEAN), 128'(0));
    check("post_flush_addr", 128'(sram_A), 128'(0));
    @(posedge CK); #1;
    wr_valid = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge CK);
    #1;
    if (exp_q.size() != 0) fail_now("post_flush_readback");

    // ---- reset with count=100 and a read in flight ----
    rd_ready = 1'b0;
    for (int k = 0; k < 150; k++) begin
      if (n_wr >= 103) break;
      wr_valid = 1'b1; wr_data = 128'(n_wr);
      @(posedge CK); #1;
    end
    wr_valid = 1'b0;
    repeat (4) @(posedge CK);
    @(negedge CK);
    check("pre_reset_count", 128'(count), 128'(100));
    @(posedge CK); #1;
    rd_ready = 1'b1;
    @(posedge CK); #1;
    mon_en = 1'b0; rd_ready = 1'b0; rst = 1'b1; wr_valid = 1'b1;
    @(posedge CK); #1;
    check("rst_state", 128'(dbg_state), 128'(0));
    check("rst_wr_ready", 128'(wr_ready), 128'(0));
    check("rst_rd_valid", 128'(rd_valid), 128'(0));
    check("rst_rd_data", rd_data, 128'(0));
    check("rst_wean", 128'(sram_WEAN), 128'(1));
    check("rst_oeb", 128'(sram_OEB), 128'(0));
    check("rst_addr", 128'({sram_A, sram_B}), 128'(0));
    check("rst_count", 128'(count), 128'(0));
    check("rst_flags", 128'({full, empty}), 128'(2'b01));
    rst = 1'b0; wr_valid = 1'b0;
    repeat (6) begin
      @(negedge CK);
      check("rst_no_stale_valid", 128'(rd_valid), 128'(0));
      check("rst_no_stale_data", rd_data, 128'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
